fibo_checker: RTL and testbench
===============================

# fibo_checker

Consumer/checker end of the Fibonacci stream interface. Drives the generator's enable (`f_en`) and samples its `f_valid`/`f_out` pair. Compares every term against an internal reference sequence 0, 1, 1, 2, 3, … MAX_FIBO, 0, 1, … and reports pass/fail with term and wrap counters. Sits in the same clock domain as the generator, as its on-chip self-test and stream sink.

## Interface
- `MAX_FIBO`, 46368: last term before the sequence restarts at 0.
- `N_TERMS`, 50: terms requested and checked per run (1..2^CNT_W-1).
- `CNT_W`, 8: width of the term and wrap counters.
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `pause` in 1: while 1 in RUN, `f_en` is held low (bubble insertion).
- `f_valid` in 1: generator valid; equals the generator's `f_en` in the same cycle.
- `f_out` in 16: generator term; updated on the edge that closes a cycle with `f_en`=1.
- `f_en` out 1: request one term per cycle high.
- `busy` out 1: state is RUN.
- `done` out 1: run completed with all terms matching; sticky until next `start`.
- `error` out 1: mismatch detected; sticky until `reset`.
- `checked_cnt` out CNT_W: terms matched in the current run.
- `wrap_cnt` out CNT_W: MAX_FIBO terms matched since reset; saturates at all-ones.
- `err_value` out 16: `f_out` value that failed.
- `err_expected` out 16: expected value at failure.

## Operation
- States: IDLE, RUN, DONE, FAIL.
- IDLE/DONE + `start`=1 → RUN. Clears `checked_cnt`, the issue counter and `done`.
- `f_en` = (state==RUN) && (issued < N_TERMS) && !`pause`. It is combinational from registers and `pause`. `issued` increments on every edge with `f_en`=1.
- `v_q` registers `f_valid` each edge. A sample is taken on an edge where `v_q`=1, and `f_out` is compared against `exp`.
- Reference model registers: `exp` (16 bits) and `nxt` (17 bits).
  - Match with `exp`==MAX_FIBO: `exp`←0, `nxt`←1, `wrap_cnt`+1.
  - Other match: `exp`←`nxt`[15:0], `nxt`←`exp`+`nxt`. The 17-bit `nxt` absorbs 28657+46368 without overflow.
- `exp`/`nxt` are cleared only by `reset`. They are not cleared by `start`, because the generator's sequence continues across runs.
- Match increments `checked_cnt`. When `checked_cnt` reaches N_TERMS, go to DONE and set `done`=1.
- Mismatch: go to FAIL, latch `err_value`/`err_expected`, set `error`=1, force `f_en`=0. FAIL is exited only by `reset`. `start` is ignored there.
- `start` in RUN or FAIL: ignored.
- `pause` never suppresses a sample already pending in `v_q`.

## Timing
- Reset values:
  - `f_en`=0, `busy`=0, `done`=0, `error`=0.
  - Counters=0; `err_value`=0; `err_expected`=0.
  - `exp`=0, `nxt`=1, `v_q`=0, state IDLE.
- Start → RUN on the edge where `start`=1. `f_en`=1 in the following cycle unless `pause` is high.
- Sample latency: the term requested in cycle k is compared at the edge ending cycle k+1.
- Unpaused run of N terms: `f_en` high for N consecutive cycles. `done` rises on the edge after the last `f_en` cycle plus one, i.e. N+1 edges after entering RUN.
- Mismatch on the final term: FAIL, not DONE.
- Reset mid-run: immediate return to IDLE. The generator is reset by the same `reset`, so the models stay aligned.

## Structure
- Shared package `fibo_pkg` holds:
  - `FIBO_W`=16;
  - `MAX_FIBO`=46368 (used by generator and checker);
  - the `fibo_chk_state_t` enum (IDLE, RUN, DONE, FAIL).
- One sub-module, `fibo_model`, holds `exp`/`nxt`. Inputs: `step`, `clock`, `reset`. Outputs: `exp` and a `at_max` flag.
- Top `fibo_checker` holds the FSM, the issue/check counters and the error latches.

## Test plan
- Reset, `start` pulse, N_TERMS=10, no pause.
  - Required: `f_en` high 10 cycles; terms 0,1,1,2,3,5,8,13,21,34 matched.
  - Required: `done`=1 at entry+11 edges; `checked_cnt`=10.
- N_TERMS=30, unpaused.
  - Required: term 25 = 46368 and term 26 = 0 both match; `wrap_cnt`=1; `done`=1.
- `pause` high on alternate cycles, N_TERMS=8.
  - Required: `f_en` toggles; all 8 terms match; `done` arrives later with no error.
- Force `f_out`=4 where 3 is expected (term 5).
  - Required: `error`=1, `err_value`=4, `err_expected`=3, `f_en`=0, state FAIL.
  - Required: later `start` is ignored.
- Two back-to-back runs of 5 terms.
  - Required: second run checks 5,8,13,21,34 (continuation); `checked_cnt` restarts at 0.
- `reset` asserted mid-run at term 3.
  - Required: all outputs return to reset values; the next run checks from 0 again.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair.
package fibo_pkg;
   localparam int FIBO_W   = 16;
   localparam int MAX_FIBO = 46368;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } fibo_chk_state_t;
endpackage

// File: rtl/fibo_model.sv
// Reference Fibonacci sequence for the checker; advances one term per step.
module fibo_model
   import fibo_pkg::*;
#(
   parameter int MAX_VAL = fibo_pkg::MAX_FIBO
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              step,
   output logic [FIBO_W-1:0] exp,
   output logic              at_max
);

   localparam logic [FIBO_W-1:0] MAX_V = FIBO_W'(MAX_VAL);

   // One extra bit so the sum just before the wrap term cannot overflow.
   logic [FIBO_W:0] nxt;

   assign at_max = (exp == MAX_V);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         exp <= '0;
         nxt <= (FIBO_W+1)'(1);
      end else if (step) begin
         if (at_max) begin
            exp <= '0;
            nxt <= (FIBO_W+1)'(1);
         end else begin
            exp <= nxt[FIBO_W-1:0];
            nxt <= {1'b0, exp} + nxt;
         end
      end
   end

endmodule

// File: rtl/fibo_checker.sv
// Stream sink and self-test for the Fibonacci generator: requests terms,
// compares each against a reference sequence and reports pass/fail.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | issuing requests and checking returned terms
//   DONE  | all N_TERMS terms matched; start launches another run
//   FAIL  | mismatch seen; held until reset
module fibo_checker
   import fibo_pkg::*;
#(
   parameter int MAX_FIBO = fibo_pkg::MAX_FIBO,
   parameter int N_TERMS  = 50,
   parameter int CNT_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              f_valid,
   input  logic [FIBO_W-1:0] f_out,
   output logic              f_en,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  checked_cnt,
   output logic [CNT_W-1:0]  wrap_cnt,
   output logic [FIBO_W-1:0] err_value,
   output logic [FIBO_W-1:0] err_expected
);

   localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(N_TERMS);
   localparam logic [CNT_W-1:0] N_LAST_M1 = CNT_W'(N_TERMS - 1);

   fibo_chk_state_t   state_q, state_d;
   logic [CNT_W-1:0]  issued_q;
   logic              v_q;
   logic [FIBO_W-1:0] exp_val;
   logic              at_max;
   logic              go, sample, match, step;

   fibo_model #(.MAX_VAL(MAX_FIBO)) u_model (
      .clock  (clock),
      .reset  (reset),
      .step   (step),
      .exp    (exp_val),
      .at_max (at_max)
   );

   assign go     = start && ((state_q == IDLE) || (state_q == DONE));
   // A pending sample is honoured regardless of pause.
   assign sample = v_q && (state_q == RUN);
   assign match  = (f_out == exp_val);
   assign step   = sample && match;
   assign f_en   = (state_q == RUN) && (issued_q < N_LAST) && !pause;
   assign busy   = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RUN;
         RUN: begin
            if (sample) begin
               if (!match)                        state_d = FAIL;
               else if (checked_cnt == N_LAST_M1) state_d = DONE;
            end
         end
         FAIL:    state_d = FAIL;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         issued_q     <= '0;
         v_q          <= 1'b0;
         checked_cnt  <= '0;
         wrap_cnt     <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_value    <= '0;
         err_expected <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= f_valid;

         if (go)        issued_q <= '0;
         else if (f_en) issued_q <= issued_q + 1'b1;

         if (go)        checked_cnt <= '0;
         else if (step) checked_cnt <= checked_cnt + 1'b1;

         if (step && at_max && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + 1'b1;

         if (go)                                            done <= 1'b0;
         else if ((state_q == RUN) && (state_d == DONE))    done <= 1'b1;

         if (sample && !match) begin
            error        <= 1'b1;
            err_value    <= f_out;
            err_expected <= exp_val;
         end
      end
   end

endmodule

// File: tb/tb_fibo_checker.sv
// Directed bench: four checker instances (N_TERMS 10/30/8/5), each fed by a
// small behavioural generator with an optional single-term corruption.
module tb_fibo_checker;

   localparam int NI = 4;

   function automatic int nt_of(input int i);
      case (i)
         0: return 10;
         1: return 30;
         2: return 8;
         default: return 5;
      endcase
   endfunction

   logic        clock = 1'b0;
   logic        reset;
   logic        start_a   [NI];
   logic        pause_a   [NI];
   logic        f_en_a    [NI];
   logic        busy_a    [NI];
   logic        done_a    [NI];
   logic        err_a     [NI];
   logic [7:0]  chk_a     [NI];
   logic [7:0]  wrap_a    [NI];
   logic [15:0] errv_a    [NI];
   logic [15:0] erre_a    [NI];
   logic [15:0] fout_a    [NI];
   int          force_term[NI];

   int checks, failures;
   int cyc, en, enp, k;

   always #5 clock = ~clock;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      logic [16:0] ga, gb;
      logic [15:0] gout;
      int          gcnt;

      always @(posedge clock or posedge reset) begin
         if (reset) begin
            ga <= 17'd0; gb <= 17'd1; gout <= 16'd0; gcnt <= 0;
         end else if (f_en_a[g]) begin
            gout <= ga[15:0];
            gcnt <= gcnt + 1;
            if (ga == 17'd46368) begin
               ga <= 17'd0; gb <= 17'd1;
            end else begin
               ga <= gb; gb <= ga + gb;
            end
         end
      end

      assign fout_a[g] = (force_term[g] != 0 && gcnt == force_term[g]) ? gout + 16'd1 : gout;

      fibo_checker #(.MAX_FIBO(46368), .N_TERMS(nt_of(g)), .CNT_W(8)) u_dut (
         .clock        (clock),
         .reset        (reset),
         .start        (start_a[g]),
         .pause        (pause_a[g]),
         .f_valid      (f_en_a[g]),
         .f_out        (fout_a[g]),
         .f_en         (f_en_a[g]),
         .busy         (busy_a[g]),
         .done         (done_a[g]),
         .error        (err_a[g]),
         .checked_cnt  (chk_a[g]),
         .wrap_cnt     (wrap_a[g]),
         .err_value    (errv_a[g]),
         .err_expected (erre_a[g])
      );
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic start_pulse(input int i);
      start_a[i] = 1'b1;
      tick();
      start_a[i] = 1'b0;
   endtask

   task automatic run(input int i, input bit pmode, input int budget,
                      output int c, output int n_en, output int n_enp);
      c = 0; n_en = 0; n_enp = 0;
      while (!done_a[i] && !err_a[i] && c < budget) begin
         pause_a[i] = pmode && c[0];
         #1;
         if (f_en_a[i]) begin
            n_en++;
            if (pause_a[i]) n_enp++;
         end
         tick();
         c++;
      end
      pause_a[i] = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         start_a[i] = 1'b0; pause_a[i] = 1'b0; force_term[i] = 0;
      end
      repeat (2) @(posedge clock);
      #1;
      check("rst_f_en",   32'(f_en_a[0]), 0);
      check("rst_busy",   32'(busy_a[0]), 0);
      check("rst_done",   32'(done_a[0]), 0);
      check("rst_error",  32'(err_a[0]),  0);
      check("rst_chk",    32'(chk_a[0]),  0);
      check("rst_wrap",   32'(wrap_a[0]), 0);
      check("rst_errv",   32'(errv_a[0]), 0);
      check("rst_erre",   32'(erre_a[0]), 0);
      reset = 1'b0;
      tick();

      // Ten terms, no pause
      start_pulse(0);
      check("t1_busy_after_start", 32'(busy_a[0]), 1);
      check("t1_f_en_after_start", 32'(f_en_a[0]), 1);
      run(0, 1'b0, 40, cyc, en, enp);
      check("t1_done_edges", 32'(cyc), 11);
      check("t1_en_cycles",  32'(en), 10);
      check("t1_done",       32'(done_a[0]), 1);
      check("t1_chk",        32'(chk_a[0]), 10);
      check("t1_error",      32'(err_a[0]), 0);
      check("t1_busy_end",   32'(busy_a[0]), 0);
      check("t1_f_en_end",   32'(f_en_a[0]), 0);

      // Thirty terms across the 46368 -> 0 wrap
      start_pulse(1);
      run(1, 1'b0, 60, cyc, en, enp);
      check("t2_done_edges", 32'(cyc), 31);
      check("t2_en_cycles",  32'(en), 30);
      check("t2_done",       32'(done_a[1]), 1);
      check("t2_wrap",       32'(wrap_a[1]), 1);
      check("t2_chk",        32'(chk_a[1]), 30);
      check("t2_error",      32'(err_a[1]), 0);

      // Eight terms with pause on alternate cycles
      start_pulse(2);
      run(2, 1'b1, 60, cyc, en, enp);
      check("t3_done_edges",   32'(cyc), 16);
      check("t3_en_cycles",    32'(en), 8);
      check("t3_en_in_pause",  32'(enp), 0);
      check("t3_done",         32'(done_a[2]), 1);
      check("t3_chk",          32'(chk_a[2]), 8);
      check("t3_error",        32'(err_a[2]), 0);

      // Corrupt the fifth term (3 -> 4)
      reset = 1'b1; tick(); reset = 1'b0; tick();
      force_term[0] = 5;
      start_pulse(0);
      run(0, 1'b0, 40, cyc, en, enp);
      check("t4_fail_edges", 32'(cyc), 6);
      check("t4_error",      32'(err_a[0]), 1);
      check("t4_errv",       32'(errv_a[0]), 4);
      check("t4_erre",       32'(erre_a[0]), 3);
      check("t4_f_en",       32'(f_en_a[0]), 0);
      check("t4_busy",       32'(busy_a[0]), 0);
      check("t4_done",       32'(done_a[0]), 0);
      check("t4_chk",        32'(chk_a[0]), 4);
      start_pulse(0);
      tick(); tick();
      check("t4_start_ign_busy",  32'(busy_a[0]), 0);
      check("t4_start_ign_f_en",  32'(f_en_a[0]), 0);
      check("t4_start_ign_error", 32'(err_a[0]), 1);
      force_term[0] = 0;

      // Back-to-back runs of five terms
      start_pulse(3);
      run(3, 1'b0, 30, cyc, en, enp);
      check("t5a_done_edges", 32'(cyc), 6);
      check("t5a_done",       32'(done_a[3]), 1);
      check("t5a_chk",        32'(chk_a[3]), 5);
      start_pulse(3);
      check("t5b_chk_cleared",  32'(chk_a[3]), 0);
      check("t5b_done_cleared", 32'(done_a[3]), 0);
      check("t5b_busy",         32'(busy_a[3]), 1);
      run(3, 1'b0, 30, cyc, en, enp);
      check("t5b_done_edges", 32'(cyc), 6);
      check("t5b_done",       32'(done_a[3]), 1);
      check("t5b_chk",        32'(chk_a[3]), 5);
      check("t5b_error",      32'(err_a[3]), 0);

      // Reset in the middle of a run
      start_pulse(1);
      k = 0;
      while (chk_a[1] != 8'd3 && k < 20) begin
         tick();
         k++;
      end
      check("t6_reached_term3", 32'(chk_a[1]), 3);
      reset = 1'b1;
      #1;
      check("t6_rst_f_en", 32'(f_en_a[1]), 0);
      check("t6_rst_busy", 32'(busy_a[1]), 0);
      check("t6_rst_chk",  32'(chk_a[1]), 0);
      check("t6_rst_done", 32'(done_a[1]), 0);
      check("t6_rst_err",  32'(err_a[1]), 0);
      reset = 1'b0;
      tick();
      start_pulse(1);
      run(1, 1'b0, 60, cyc, en, enp);
      check("t6_rerun_edges", 32'(cyc), 31);
      check("t6_rerun_done",  32'(done_a[1]), 1);
      check("t6_rerun_wrap",  32'(wrap_a[1]), 1);
      check("t6_rerun_error", 32'(err_a[1]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
